// File: rtl/ac_e_register_if.sv
// Bus between the AC arithmetic unit / control sequencer and the AC/E register block.
// Carries the result bus, carry, op strobe, and the registered AC/E/status outputs.
// master = arithmetic unit + sequencer side, slave = ac_e_register.
interface ac_e_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] ac_data;
  logic             cout;
  logic             op_valid;
  logic [3:0]       op;
  logic [WIDTH-1:0] ac;
  logic             e;
  logic             op_done;
  logic             skip;
  logic             ac_zero;

  modport master (
    output ac_data, cout, op_valid, op,
    input  ac, e, op_done, skip, ac_zero
  );

  modport slave (
    input  ac_data, cout, op_valid, op,
    output ac, e, op_done, skip, ac_zero
  );
endinterface

// File: rtl/ac_e_register.sv
// Accumulator, E flip-flop and skip-test logic; one register op per accepted strobe.
// Latency: AC/E update at the sampling edge; op_done/skip/ac_zero registered, valid the next cycle.
// No backpressure: every op_valid strobe is accepted. Skip tests (ops 9-12) built only with AC_SKIP_EN.
module ac_e_register #(
  parameter int WIDTH = 16  // must match the WIDTH of the connected ac_e_if
) (
  input  logic  clk,
  input  logic  rst,
  ac_e_if.slave bus
);

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_ADD  = 4'd2,
    OP_CIR  = 4'd3,
    OP_CIL  = 4'd4,
    OP_CLA  = 4'd5,
    OP_CLE  = 4'd6,
    OP_CME  = 4'd7,
    OP_INC  = 4'd8,
    OP_SPA  = 4'd9,
    OP_SNA  = 4'd10,
    OP_SZA  = 4'd11,
    OP_SZE  = 4'd12
  } op_t;

  logic [WIDTH-1:0] ac_q;
  logic             e_q;
  logic             done_q;
  logic             skip_q;
  logic             zero_q;

  logic [WIDTH-1:0] ac_nxt;
  logic             e_nxt;
  logic             skip_nxt;

  // Next AC/E for the strobed op; everything holds when no op is presented.
  always_comb begin
    ac_nxt = ac_q;
    e_nxt  = e_q;
    if (bus.op_valid) begin
      case (op_t'(bus.op))
        OP_LOAD: ac_nxt = bus.ac_data;
        OP_ADD: begin
          ac_nxt = bus.ac_data;
          e_nxt  = bus.cout;
        end
        // The arithmetic unit supplies the shifted value; E catches the bit shifted out.
        OP_CIR: begin
          ac_nxt = bus.ac_data;
          e_nxt  = ac_q[0];
        end
        OP_CIL: begin
          ac_nxt = bus.ac_data;
          e_nxt  = ac_q[WIDTH-1];
        end
        OP_CLA: ac_nxt = '0;
        OP_CLE: e_nxt  = 1'b0;
        OP_CME: e_nxt  = ~e_q;
        OP_INC: ac_nxt = ac_q + 1'b1;  // wraps modulo 2^WIDTH, E untouched
        default: ;                     // NOP, skip tests, reserved codes
      endcase
    end
  end

  // Skip condition evaluated on the pre-edge AC/E.
  always_comb begin
    skip_nxt = 1'b0;
`ifdef AC_SKIP_EN
    if (bus.op_valid) begin
      case (op_t'(bus.op))
        OP_SPA:  skip_nxt = ~ac_q[WIDTH-1];
        OP_SNA:  skip_nxt = ac_q[WIDTH-1];
        OP_SZA:  skip_nxt = (ac_q == '0);
        OP_SZE:  skip_nxt = ~e_q;
        default: skip_nxt = 1'b0;
      endcase
    end
`endif
  end

  // State and registered status; reset also cancels a pending op_done/skip pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_q   <= '0;
      e_q    <= 1'b0;
      done_q <= 1'b0;
      skip_q <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      ac_q   <= ac_nxt;
      e_q    <= e_nxt;
      done_q <= bus.op_valid;
      skip_q <= skip_nxt;
      zero_q <= (ac_nxt == '0);
    end
  end

  assign bus.ac      = ac_q;
  assign bus.e       = e_q;
  assign bus.op_done = done_q;
  assign bus.skip    = skip_q;
  assign bus.ac_zero = zero_q;

endmodule

// File: doc/ac_e_register.md
# ac_e_register

Accumulator register, E (extend) flip-flop and skip-test logic of the basic computer datapath. Sits directly downstream of the AC arithmetic unit: captures its 16-bit result and carry-out, stores AC and E, and feeds both back to the arithmetic unit's AC and E inputs. Executes one register operation per accepted strobe and reports completion and any skip condition to the control sequencer.

## Interface
- WIDTH, 16, AC width; the skip-test sign bit is AC[WIDTH-1].
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ac_data  input  WIDTH  result bus from the AC arithmetic unit.
- cout  input  1  carry-out from the arithmetic unit's adder.
- op_valid  input  1  operation strobe; sampled only on the rising edge.
- op  input  4  operation code, sampled with op_valid.
- ac  output  WIDTH  accumulator contents; feeds the arithmetic unit's AC input.
- e  output  1  E flip-flop; feeds the arithmetic unit's E input.
- op_done  output  1  one-cycle pulse, the cycle after an accepted op.
- skip  output  1  skip request; valid only while op_done=1, else 0.
- ac_zero  output  1  registered (ac == 0).

## Operation
- Op codes, applied when op_valid=1 at the clock edge:
  - 0 NOP.
  - 1 LOAD: AC <= ac_data. Covers AND, LDA, INP, CMA and any other arithmetic-unit result with no E effect.
  - 2 ADD: AC <= ac_data; E <= cout.
  - 3 CIR: AC <= ac_data; E <= old AC[0]. The arithmetic unit must be driving SHR.
  - 4 CIL: AC <= ac_data; E <= old AC[WIDTH-1]. The arithmetic unit must be driving SHL.
  - 5 CLA: AC <= 0.
  - 6 CLE: E <= 0.
  - 7 CME: E <= ~E.
  - 8 INC: AC <= AC + 1, modulo 2^WIDTH. E is unchanged, including on wrap from all-ones to 0.
  - 9 SPA: skip = (AC[WIDTH-1] == 0).
  - 10 SNA: skip = (AC[WIDTH-1] == 1).
  - 11 SZA: skip = (AC == 0).
  - 12 SZE: skip = (E == 0).
  - 13-15: reserved, treated as NOP. op_done still pulses; skip=0.
- Operands:
  - Skip tests evaluate AC and E as they are before the edge.
  - Skip tests never modify AC or E.
  - CIR/CIL take E from the pre-edge AC.
- op_valid and op are ignored when op_valid=0. AC and E hold their values.
- Back-to-back ops on consecutive cycles are legal. Each op sees the results of the previous one.
- ac_zero is recomputed from the new AC on every AC update. It is never combinational from ac_data.

## Timing
- Reset values while rst=1: ac=0, e=0, op_done=0, skip=0, ac_zero=1.
- Reset takes effect immediately, independent of clk.
- Reset asserted mid-operation cancels any pending op_done/skip pulse.
- First op accepted: the first rising edge with rst=0 and op_valid=1.
- Latency:
  - AC/E update at the edge that samples op_valid.
  - op_done and skip are registered and high for exactly the following cycle.
  - Throughput: one op per cycle.
- ac_zero and the new ac are visible in the same cycle as op_done.
- No backpressure: every strobe is accepted.
- The arithmetic unit is combinational on ac/e. ac_data must settle within the same cycle op_valid is presented.

## Configuration
- AC_SKIP_EN defined:
  - Op codes 9-12 perform skip tests as above.
- AC_SKIP_EN undefined:
  - Op codes 9-12 behave as NOP.
  - skip is tied to 0; op_done still pulses.
  - The skip comparison logic is not synthesized.

## Test plan
- Reset value check: assert rst asynchronously between edges -> ac=0x0000, e=0, op_done=0, skip=0, ac_zero=1 immediately.
- ADD then INC wrap:
  - Load ac_data=0xFFFF (op 1), then ADD with ac_data=0x0001, cout=1 -> ac=0x0001, e=1.
  - Reload 0xFFFF, then INC -> ac=0x0000, ac_zero=1, e unchanged.
- Rotates, starting from ac=0x8001, e=0:
  - CIR with ac_data=0x4000 -> ac=0x4000, e=1.
  - Then CIL with ac_data=0x8001 -> ac=0x8001, e=0.
- E ops: CLE -> e=0; CME twice on consecutive cycles -> e=1 then e=0; op_done high on each following cycle.
- Skips with AC_SKIP_EN defined:
  - ac=0x8000: SNA -> skip=1; SPA -> skip=0; SZA -> skip=0.
  - After CLA: SZA -> skip=1.
  - With e=0: SZE -> skip=1.
  - Rebuilt without the macro: all four give skip=0.
- Mid-op reset and idle hold:
  - Strobe LOAD 0x1234, then assert rst before the op_done cycle ends -> op_done drops, ac=0.
  - Then 10 cycles with op_valid=0 -> no state change.
